// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and clear-controller state for the multi-port register file
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits with set/clear/sweep and busy lookup
module regfile_scoreboard #(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr0_en,
    input  logic [AW-1:0]     clr0_addr,
    input  logic              clr1_en,
    input  logic [AW-1:0]     clr1_addr,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              sweep_en,
    input  logic [AW-1:0]     sweep_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    // Set is applied after the clears so an issue wins over a same-cycle write.
    always_comb begin
        pend_nxt = pend;
        if (clr0_en) pend_nxt[clr0_addr] = 1'b0;
        if (clr1_en) pend_nxt[clr1_addr] = 1'b0;
        if (set_en) pend_nxt[set_addr] = 1'b1;
        if (sweep_en) pend_nxt[sweep_addr] = 1'b0;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= '0;
        else pend <= pend_nxt;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_busy
        logic [AW-1:0] a;
        assign a = rd_addr[k*AW +: AW];
        assign rd_busy[k] = pend[a] && !(clr0_en && clr0_addr == a)
                                    && !(clr1_en && clr1_addr == a);
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with write bypass, pending scoreboard and sweep clear
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    clr_state_e      state;
    clr_state_e      state_nxt;
    logic [AW-1:0]   cnt;
    logic            idle;
    logic            last;
    logic            we0_e;
    logic            we1_e;
    logic            iss_e;
    logic [XLEN-1:0] regs [NREG];

    // Writes and issues are only honoured outside the sweep, and never to r0.
    assign idle  = (state == IDLE);
    assign last  = (cnt == AW'(NREG - 1));
    assign we0_e = idle && we0 && (waddr0 != '0);
    assign we1_e = idle && we1 && (waddr1 != '0);
    assign iss_e = idle && iss_valid && (iss_addr != '0);
    assign clr_busy = !idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= !idle && last;
            if (idle) begin
                if (clr_req) cnt <= AW'(1);
            end else if (last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + AW'(1);
            end
        end
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (!idle) begin
            regs[cnt] <= '0;
        end else begin
            if (we0_e) regs[waddr0] <= wdata0;
            if (we1_e) regs[waddr1] <= wdata1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[k*AW +: AW];
        assign rd_data[k*XLEN +: XLEN] = (we1_e && waddr1 == a) ? wdata1 :
                                         (we0_e && waddr0 == a) ? wdata0 : regs[a];
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .clr0_en    (we0_e),
        .clr0_addr  (waddr0),
        .clr1_en    (we1_e),
        .clr1_addr  (waddr1),
        .set_en     (iss_e),
        .set_addr   (iss_addr),
        .sweep_en   (!idle),
        .sweep_addr (cnt),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized model-checked bench for regfile_mp
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = $clog2(NREG);

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we0, we1, iss_valid, clr_req;
    logic [AW-1:0]       waddr0, waddr1, iss_addr;
    logic [XLEN-1:0]     wdata0, wdata1;
    logic                clr_busy, clr_done;

    logic [AW-1:0] ra [NRD];

    logic [XLEN-1:0] mreg  [NREG];
    bit              mpend [NREG];
    bit              m_clr;
    int              m_idx;
    bit              m_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .AW(AW)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            mreg[i]  = '0;
            mpend[i] = 1'b0;
        end
        m_clr  = 1'b0;
        m_idx  = 0;
        m_done = 1'b0;
    endtask

    // What the register file must do at one rising edge, given the inputs present before it.
    task automatic model_update();
        bit fin;
        if (rst) begin
            model_reset();
            return;
        end
        fin = 1'b0;
        if (!m_clr) begin
            if (we0 && waddr0 != 0) begin mreg[waddr0] = wdata0; mpend[waddr0] = 1'b0; end
            if (we1 && waddr1 != 0) begin mreg[waddr1] = wdata1; mpend[waddr1] = 1'b0; end
            if (iss_valid && iss_addr != 0) mpend[iss_addr] = 1'b1;
            if (clr_req) begin m_clr = 1'b1; m_idx = 1; end
        end else begin
            mreg[m_idx]  = '0;
            mpend[m_idx] = 1'b0;
            if (m_idx == NREG - 1) begin m_clr = 1'b0; fin = 1'b1; end
            else m_idx++;
        end
        m_done = fin;
    endtask

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
        if (!m_clr && a != 0 && we1 && waddr1 == a) return wdata1;
        if (!m_clr && a != 0 && we0 && waddr0 == a) return wdata0;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        bit hit;
        hit = !m_clr && a != 0 && ((we0 && waddr0 == a) || (we1 && waddr1 == a));
        return mpend[a] && !hit;
    endfunction

    // Present read addresses, let combinational paths settle, compare against the model.
    task automatic settle();
        for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = ra[k];
        #1;
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("rd_data[%0d] r%0d", k, ra[k]), 64'(rd_data[k*XLEN +: XLEN]), 64'(exp_data(ra[k])));
            chk($sformatf("rd_busy[%0d] r%0d", k, ra[k]), 64'(rd_busy[k]), 64'(exp_busy(ra[k])));
        end
        chk("clr_busy", 64'(clr_busy), 64'(m_clr));
        chk("clr_done", 64'(clr_done), 64'(m_done));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic quiet();
        we0 = 0; we1 = 0; iss_valid = 0; clr_req = 0;
        waddr0 = '0; waddr1 = '0; iss_addr = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    int busy_cnt, done_cnt;

    initial begin
        rst = 1'b1;
        quiet();
        for (int k = 0; k < NRD; k++) ra[k] = '0;
        model_reset();
        @(negedge clk);
        ra[0] = AW'(5);
        settle();
        chk("reset r5 data", 64'(rd_data[0 +: XLEN]), 64'h0);
        chk("reset r5 busy", 64'(rd_busy[0]), 64'h0);
        tick();
        rst = 1'b0;

        // r0 is hardwired to zero
        we0 = 1; waddr0 = '0; wdata0 = '1; ra[0] = '0;
        settle();
        chk("r0 bypass", 64'(rd_data[0 +: XLEN]), 64'h0);
        tick();
        quiet();
        settle();
        chk("r0 after write", 64'(rd_data[0 +: XLEN]), 64'h0);
        tick();

        // dual write to r7, port 1 wins
        we0 = 1; waddr0 = AW'(7); wdata0 = XLEN'('h11);
        we1 = 1; waddr1 = AW'(7); wdata1 = XLEN'('h22);
        ra[0] = AW'(7); ra[1] = AW'(7);
        settle();
        chk("r7 bypass", 64'(rd_data[0 +: XLEN]), 64'h22);
        tick();
        quiet();
        settle();
        chk("r7 stored", 64'(rd_data[XLEN +: XLEN]), 64'h22);
        tick();

        // pending tracking on r9
        iss_valid = 1; iss_addr = AW'(9);
        cyc();
        quiet(); ra[0] = AW'(9);
        settle();
        chk("r9 busy after iss", 64'(rd_busy[0]), 64'h1);
        tick();
        we0 = 1; waddr0 = AW'(9); wdata0 = XLEN'('h5);
        settle();
        chk("r9 write bypass", 64'(rd_data[0 +: XLEN]), 64'h5);
        chk("r9 busy masked", 64'(rd_busy[0]), 64'h0);
        tick();
        quiet();
        iss_valid = 1; iss_addr = AW'(9); we1 = 1; waddr1 = AW'(9); wdata1 = XLEN'('h6);
        cyc();
        quiet();
        settle();
        chk("r9 set beats clear", 64'(rd_busy[0]), 64'h1);
        tick();

        // fill everything, then sweep with writes attempted throughout
        for (int i = 1; i < NREG; i++) begin
            we0 = 1; waddr0 = AW'(i); wdata0 = XLEN'(i * 3 + 1);
            iss_valid = 1; iss_addr = AW'(i);
            ra[0] = AW'(i);
            cyc();
        end
        quiet();
        clr_req = 1;
        cyc();
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < NREG + 4; c++) begin
            quiet();
            we0 = 1; waddr0 = AW'($urandom_range(1, NREG - 1)); wdata0 = XLEN'($urandom | 1);
            we1 = 1; waddr1 = AW'($urandom_range(1, NREG - 1)); wdata1 = XLEN'($urandom | 1);
            iss_valid = 1; iss_addr = AW'($urandom_range(1, NREG - 1));
            clr_req = 1;
            if (!m_clr) quiet();
            for (int k = 0; k < NRD; k++) ra[k] = AW'($urandom_range(0, NREG - 1));
            settle();
            busy_cnt += int'(clr_busy);
            done_cnt += int'(clr_done);
            tick();
        end
        quiet();
        chk("sweep busy cycles", 64'(busy_cnt), 64'(NREG - 1));
        chk("sweep done pulses", 64'(done_cnt), 64'h1);
        for (int i = 0; i < NREG; i++) begin
            ra[0] = AW'(i);
            settle();
            chk("post sweep data", 64'(rd_data[0 +: XLEN]), 64'h0);
            chk("post sweep busy", 64'(rd_busy[0]), 64'h0);
            tick();
        end

        // randomized traffic with occasional sweeps
        for (int n = 0; n < 700; n++) begin
            we0 = ($urandom_range(0, 2) == 0);
            we1 = ($urandom_range(0, 2) == 0);
            waddr0 = AW'($urandom_range(0, NREG - 1));
            waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, NREG - 1));
            wdata0 = XLEN'({$urandom, $urandom});
            wdata1 = XLEN'({$urandom, $urandom});
            iss_valid = ($urandom_range(0, 1) == 0);
            iss_addr = ($urandom_range(0, 3) == 0) ? waddr1 : AW'($urandom_range(0, NREG - 1));
            clr_req = ($urandom_range(0, 89) == 0);
            for (int k = 0; k < NRD; k++) begin
                case ($urandom_range(0, 3))
                    0: ra[k] = waddr0;
                    1: ra[k] = waddr1;
                    2: ra[k] = iss_addr;
                    default: ra[k] = AW'($urandom_range(0, NREG - 1));
                endcase
            end
            cyc();
        end
        quiet();
        for (int c = 0; c < NREG + 2; c++) cyc();

        // reset in the middle of a sweep
        for (int i = 1; i < NREG; i++) begin
            we1 = 1; waddr1 = AW'(i); wdata1 = XLEN'(i + 100);
            iss_valid = 1; iss_addr = AW'(i);
            cyc();
        end
        quiet();
        clr_req = 1;
        cyc();
        quiet();
        for (int c = 0; c < 9; c++) cyc();
        chk("sweep index before abort", 64'(m_idx), 64'd10);
        rst = 1'b1;
        model_reset();
        settle();
        chk("abort clr_busy", 64'(clr_busy), 64'h0);
        chk("abort clr_done", 64'(clr_done), 64'h0);
        tick();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < NREG; i++) begin
            ra[0] = AW'(i);
            ra[NRD-1] = AW'(NREG - 1 - i);
            settle();
            done_cnt += int'(clr_done);
            chk("abort data", 64'(rd_data[0 +: XLEN]), 64'h0);
            chk("abort busy", 64'(rd_busy[0]), 64'h0);
            tick();
        end
        chk("abort no done", 64'(done_cnt), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
